mem_wb_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage; next generation of the plain MEM/WB flip-flop bank.

---
 rtl/mem_wb_stage.sv | 141 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, a one-entry skid buffer,
// flush, and the writeback result mux.
// The main slot drives the WB outputs. The skid slot catches the one entry that
// arrives while WB is stalled. Because of this, in_ready is a plain register
// and has no combinational path from out_ready.
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SRC_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  RegWriteM,
    input  logic [SRC_W-1:0]      ResultSrcM,
    input  logic [DATA_W-1:0]     ALUResultM,
    input  logic [DATA_W-1:0]     ReadDataM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [DATA_W-1:0]     PCPlus4M,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  RegWriteW,
    output logic [SRC_W-1:0]      ResultSrcW,
    output logic [DATA_W-1:0]     ALUResultW,
    output logic [DATA_W-1:0]     ReadDataW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic [DATA_W-1:0]     PCPlus4W,
    output logic [DATA_W-1:0]     ResultW
);

    // Main slot
    logic                  r_main_valid;
    logic                  r_main_regwrite;
    logic [SRC_W-1:0]      r_main_src;
    logic [DATA_W-1:0]     r_main_alu;
    logic [DATA_W-1:0]     r_main_read;
    logic [REG_ADDR_W-1:0] r_main_rd;
    logic [DATA_W-1:0]     r_main_pc4;

    // Skid slot
    logic                  r_skid_valid;
    logic                  r_skid_regwrite;
    logic [SRC_W-1:0]      r_skid_src;
    logic [DATA_W-1:0]     r_skid_alu;
    logic [DATA_W-1:0]     r_skid_read;
    logic [REG_ADDR_W-1:0] r_skid_rd;
    logic [DATA_W-1:0]     r_skid_pc4;

    logic w_accept;
    logic w_fire;
    logic w_main_free;

    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & ~r_skid_valid;
    assign w_fire      = r_main_valid & out_ready;
    assign w_main_free = ~r_main_valid | w_fire;

    // Main slot: refill from the skid slot first (this keeps entries in order),
    // otherwise take the incoming entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid    <= 1'b0;
            r_main_regwrite <= 1'b0;
            r_main_src      <= '0;
            r_main_alu      <= '0;
            r_main_read     <= '0;
            r_main_rd       <= '0;
            r_main_pc4      <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid    <= 1'b1;
                r_main_regwrite <= r_skid_regwrite;
                r_main_src      <= r_skid_src;
                r_main_alu      <= r_skid_alu;
                r_main_read     <= r_skid_read;
                r_main_rd       <= r_skid_rd;
                r_main_pc4      <= r_skid_pc4;
            end else if (w_accept) begin
                r_main_valid    <= 1'b1;
                r_main_regwrite <= RegWriteM;
                r_main_src      <= ResultSrcM;
                r_main_alu      <= ALUResultM;
                r_main_read     <= ReadDataM;
                r_main_rd       <= RdM;
                r_main_pc4      <= PCPlus4M;
            end else begin
                r_main_valid <= 1'b0;
            end
        end
    end

    // Skid slot: fills only when the main slot is held by a stalled consumer.
    // It drains into the main slot as soon as that slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_valid    <= 1'b0;
            r_skid_regwrite <= 1'b0;
            r_skid_src      <= '0;
            r_skid_alu      <= '0;
            r_skid_read     <= '0;
            r_skid_rd       <= '0;
            r_skid_pc4      <= '0;
        end else if (flush) begin
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            r_skid_valid <= 1'b0;
        end else if (w_accept) begin
            r_skid_valid    <= 1'b1;
            r_skid_regwrite <= RegWriteM;
            r_skid_src      <= ResultSrcM;
            r_skid_alu      <= ALUResultM;
            r_skid_read     <= ReadDataM;
            r_skid_rd       <= RdM;
            r_skid_pc4      <= PCPlus4M;
        end
    end

    assign out_valid  = r_main_valid;
    assign RegWriteW  = r_main_regwrite & r_main_valid;
    assign ResultSrcW = r_main_src;
    assign ALUResultW = r_main_alu;
    assign ReadDataW  = r_main_read;
    assign RdW        = r_main_rd;
    assign PCPlus4W   = r_main_pc4;

    // Writeback mux. Encoding 11 and any wider unused codes select zero.
    always_comb begin
        ResultW = '0;
        if (r_main_src == SRC_W'(0))
            ResultW = r_main_alu;
        else if (r_main_src == SRC_W'(1))
            ResultW = r_main_read;
        else if (r_main_src == SRC_W'(2))
            ResultW = r_main_pc4;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage. The queue holds the entries that should
// currently be inside the stage, oldest first.
module tb_mem_wb_stage;

    typedef struct packed {
        logic        rw;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rd_data;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] ReadDataM;
    logic [4:0]  RdM;
    logic [31:0] PCPlus4M;
    logic        out_valid;
    logic        out_ready;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W;
    logic [31:0] ResultW;

    int     n_checks = 0;
    int     n_fail   = 0;
    entry_t sb[$];

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
        .ReadDataM(ReadDataM), .RdM(RdM), .PCPlus4M(PCPlus4M),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W), .ResultW(ResultW)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wb_mux(input entry_t e);
        case (e.src)
            2'd0:    return e.alu;
            2'd1:    return e.rd_data;
            2'd2:    return e.pc4;
            default: return 32'h0;
        endcase
    endfunction

    function automatic entry_t mk(input logic rw, input logic [1:0] src, input logic [31:0] alu,
                                  input logic [31:0] rdd, input logic [4:0] rd, input logic [31:0] pc4);
        entry_t e;
        e.rw = rw; e.src = src; e.alu = alu; e.rd_data = rdd; e.rd = rd; e.pc4 = pc4;
        return e;
    endfunction

    function automatic entry_t rand_entry();
        return mk(1'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
    endfunction

    // Handshake status that the model predicts for the current cycle.
    task automatic check_status();
        check_val("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        check_val("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        if (sb.size() == 0)
            check_val("regwrite_idle", 32'(RegWriteW), 32'h0);
    endtask

    // Drive one cycle from the negedge, update the model at the posedge,
    // and check the status at the next negedge.
    task automatic step(input logic v, input logic rdy, input logic fl, input entry_t e);
        entry_t f;
        logic   acc;
        logic   fi;
        in_valid = v; out_ready = rdy; flush = fl;
        RegWriteM = e.rw; ResultSrcM = e.src; ALUResultM = e.alu;
        ReadDataM = e.rd_data; RdM = e.rd; PCPlus4M = e.pc4;
        acc = v && (sb.size() < 2);
        fi  = rdy && (sb.size() > 0);
        if (fi) begin
            f = sb.pop_front();
            check_val("rd", 32'(RdW), 32'(f.rd));
            check_val("alu", ALUResultW, f.alu);
            check_val("read", ReadDataW, f.rd_data);
            check_val("pc4", PCPlus4W, f.pc4);
            check_val("src", 32'(ResultSrcW), 32'(f.src));
            check_val("regwrite", 32'(RegWriteW), 32'(f.rw));
            check_val("result", ResultW, wb_mux(f));
        end
        @(posedge clk);
        if (fl)
            sb.delete();
        else if (acc)
            sb.push_back(e);
        @(negedge clk);
        check_status();
    endtask

    entry_t z;
    entry_t ea;
    entry_t eb;
    entry_t ec;

    initial begin
        z = '0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        RegWriteM = 1'b0; ResultSrcM = 2'd0; ALUResultM = '0; ReadDataM = '0; RdM = '0; PCPlus4M = '0;

        // Reset state
        #3;
        check_val("rst_out_valid", 32'(out_valid), 32'h0);
        check_val("rst_regwrite", 32'(RegWriteW), 32'h0);
        check_val("rst_result", ResultW, 32'h0);
        check_val("rst_alu", ALUResultW, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'h1);

        // Streaming with out_ready held high
        ea = mk(1'b1, 2'd0, 32'h10, 32'h0, 5'd5, 32'h0);
        eb = mk(1'b1, 2'd1, 32'h0, 32'hAB, 5'd6, 32'h0);
        step(1'b1, 1'b1, 1'b0, ea);
        check_val("stream_a_result", ResultW, 32'h10);
        step(1'b1, 1'b1, 1'b0, eb);
        check_val("stream_b_result", ResultW, 32'hAB);
        step(1'b0, 1'b1, 1'b0, z);

        // Skid buffer
        ea = mk(1'b1, 2'd0, 32'hA0A0, 32'h1, 5'd1, 32'h4);
        eb = mk(1'b0, 2'd1, 32'hB0B0, 32'h2, 5'd2, 32'h8);
        step(1'b1, 1'b0, 1'b0, ea);
        step(1'b1, 1'b0, 1'b0, eb);
        check_val("skid_in_ready_low", 32'(in_ready), 32'h0);
        step(1'b0, 1'b1, 1'b0, z);
        check_val("skid_a_then_b", 32'(RdW), 32'd2);
        step(1'b0, 1'b1, 1'b0, z);
        check_val("skid_in_ready_high", 32'(in_ready), 32'h1);

        // Flush with A held, B skidded, C offered
        ec = mk(1'b1, 2'd0, 32'hC0C0, 32'h3, 5'd3, 32'hC);
        step(1'b1, 1'b0, 1'b0, ea);
        step(1'b1, 1'b0, 1'b0, eb);
        step(1'b1, 1'b0, 1'b1, ec);
        check_val("flush_out_valid", 32'(out_valid), 32'h0);
        check_val("flush_regwrite", 32'(RegWriteW), 32'h0);
        step(1'b0, 1'b1, 1'b0, z);
        step(1'b0, 1'b1, 1'b0, z);

        // JAL result and the zero encoding
        ea = mk(1'b1, 2'd2, 32'h55, 32'h66, 5'd1, 32'h104);
        eb = mk(1'b1, 2'd3, 32'h55, 32'h66, 5'd7, 32'h104);
        step(1'b1, 1'b0, 1'b0, ea);
        check_val("jal_result", ResultW, 32'h104);
        check_val("jal_regwrite", 32'(RegWriteW), 32'h1);
        step(1'b1, 1'b1, 1'b0, eb);
        check_val("src11_result", ResultW, 32'h0);
        step(1'b0, 1'b1, 1'b0, z);

        // Reset while stalled: the held entry is lost
        step(1'b1, 1'b0, 1'b0, ea);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 32'(out_valid), 32'h0);
        check_val("midrst_regwrite", 32'(RegWriteW), 32'h0);
        check_val("midrst_result", ResultW, 32'h0);
        sb.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check_status();

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 55),
                 1'($urandom_range(0, 99) < 3), rand_entry());
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, z);
        check_val("drain_empty", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
